// File: rtl/exec_wb_stage_if.sv
// Execute/writeback stage bus: upstream ALU result + control, downstream
// register-file writeback port, flush, and the architectural flags.
interface exec_wb_stage_if #(
  parameter int N  = 32,
  parameter int RW = 4
) ();

  // Upstream (execute) side
  logic [N-1:0]  alu_result;
  logic          alu_neg;
  logic          alu_z;
  logic          alu_c;
  logic          alu_v;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_rd;
  logic          in_wr;
  logic          in_setf;
  logic [3:0]    in_cond;
  logic          flush;

  // Downstream (writeback) side
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [RW-1:0] out_rd;
  logic          out_we;

  // Architectural flags {N,Z,C,V}
  logic [3:0]    nzcv;

  // Driver of the stage inputs / consumer of its outputs
  modport master (
    output alu_result, alu_neg, alu_z, alu_c, alu_v,
    output in_valid, in_rd, in_wr, in_setf, in_cond, flush,
    output out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we, nzcv
  );

  // The stage itself
  modport slave (
    input  alu_result, alu_neg, alu_z, alu_c, alu_v,
    input  in_valid, in_rd, in_wr, in_setf, in_cond, flush,
    input  out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we, nzcv
  );

endinterface

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: evaluates the condition code against the
// architectural flags at input transfer, optionally updates the flags, and
// queues the writeback entry in a two-entry FIFO skid buffer.
module exec_wb_stage #(
  parameter int N  = 32,
  parameter int RW = 4
) (
  input  logic            clk,
  input  logic            rst,
  exec_wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t          occ_q, occ_d;

  logic [N-1:0]  data_q [2];
  logic [RW-1:0] rd_q   [2];
  logic          we_q   [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic          in_ready_q;
  logic [3:0]    nzcv_q;

  logic          push;
  logic          pop;
  logic          cond_pass;
  logic          entry_we;
  logic          flags_we;
  logic          f_n, f_z, f_c, f_v;

  assign f_n = nzcv_q[3];
  assign f_z = nzcv_q[2];
  assign f_c = nzcv_q[1];
  assign f_v = nzcv_q[0];

  // Condition-code evaluation against the flags held before this edge
  always_comb begin
    cond_pass = 1'b0;
    unique case (bus.in_cond)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = ~f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = ~f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = ~f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = ~f_v;
      4'b1000: cond_pass = f_c & ~f_z;
      4'b1001: cond_pass = ~f_c | f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = ~f_z & (f_n == f_v);
      4'b1101: cond_pass = f_z | (f_n != f_v);
      default: cond_pass = 1'b1;
    endcase
  end

  // Occupancy next-state and transfer qualification; flush overrides all
  always_comb begin
    occ_d    = occ_q;
    push     = 1'b0;
    pop      = 1'b0;
    entry_we = 1'b0;
    flags_we = 1'b0;
    if (bus.flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      push     = bus.in_valid & in_ready_q;
      pop      = (occ_q != OCC_EMPTY) & bus.out_ready;
      entry_we = bus.in_wr & cond_pass;
      flags_we = push & cond_pass & bus.in_setf;
      unique case (occ_q)
        OCC_EMPTY: if (push) occ_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_d = OCC_FULL;
          else if (pop && !push) occ_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop && !push) occ_d = OCC_ONE;
        default:   occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= OCC_EMPTY;
    else      occ_q <= occ_d;
  end

  // Buffer storage, pointers, registered in_ready and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        we_q[i]   <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      nzcv_q     <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= bus.alu_result;
          rd_q[wr_ptr_q]   <= bus.in_rd;
          we_q[wr_ptr_q]   <= entry_we;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
      // Ready depends only on next occupancy, so no path from out_ready
      in_ready_q <= (occ_d != OCC_FULL);
      if (flags_we)
        nzcv_q <= {bus.alu_neg, bus.alu_z, bus.alu_c, bus.alu_v};
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (occ_q != OCC_EMPTY);
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_rd    = rd_q[rd_ptr_q];
  assign bus.out_we    = (occ_q != OCC_EMPTY) & we_q[rd_ptr_q];
  assign bus.nzcv      = nzcv_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: queue-based reference model plus directed
// sequences with literal expectations.
module tb_exec_wb_stage;

  logic clk = 1'b0;
  logic rst;

  exec_wb_stage_if #(.N(32), .RW(4)) bus ();

  exec_wb_stage #(.N(32), .RW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  rd;
    logic        we;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_nzcv = 4'b0000;
  logic       m_rdy  = 1'b0;

  // ARM-style: pairs of codes share a base test, odd code inverts it
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !r : r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_nzcv = 4'b0000;
      m_rdy  = 1'b0;
    end else begin
      logic psh, pp, ok;
      psh = bus.in_valid && m_rdy;
      pp  = (mq.size() > 0) && bus.out_ready;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (pp) void'(mq.pop_front());
        if (psh) begin
          ok = cond_ok(bus.in_cond, m_nzcv);
          mq.push_back('{bus.alu_result, bus.in_rd, bus.in_wr && ok});
          if (ok && bus.in_setf)
            m_nzcv = {bus.alu_neg, bus.alu_z, bus.alu_c, bus.alu_v};
        end
      end
      m_rdy = (mq.size() < 2);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    chk("nzcv", {28'd0, bus.nzcv}, {28'd0, m_nzcv});
    if (mq.size() > 0) begin
      chk("out_data", bus.out_data, mq[0].d);
      chk("out_rd", {28'd0, bus.out_rd}, {28'd0, mq[0].rd});
      chk("out_we", {31'd0, bus.out_we}, {31'd0, mq[0].we});
    end else begin
      chk("out_we_idle", {31'd0, bus.out_we}, 32'd0);
    end
    if (!rst) begin
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_rd", {28'd0, bus.out_rd}, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic [3:0] f,
                     input logic [3:0] rd, input logic wr, input logic setf,
                     input logic [3:0] cc);
    bus.in_valid   = v;
    bus.alu_result = d;
    {bus.alu_neg, bus.alu_z, bus.alu_c, bus.alu_v} = f;
    bus.in_rd      = rd;
    bus.in_wr      = wr;
    bus.in_setf    = setf;
    bus.in_cond    = cc;
  endtask

  task automatic idle();
    put(1'b0, 32'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hE);
  endtask

  initial begin
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_nzcv", {28'd0, bus.nzcv}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Single AL instruction, 1-cycle latency
    put(1'b1, 32'h5, 4'b0000, 4'd3, 1'b1, 1'b1, 4'hE);
    tick();
    idle();
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_data", bus.out_data, 32'h5);
    chk("lat_rd", {28'd0, bus.out_rd}, 32'd3);
    chk("lat_we", {31'd0, bus.out_we}, 32'd1);
    chk("lat_nzcv", {28'd0, bus.nzcv}, 32'd0);
    tick();

    // SUBS setting Z, then EQ sees it; then NE fails and leaves flags alone
    put(1'b1, 32'h0, 4'b0100, 4'd1, 1'b1, 1'b1, 4'hE);
    tick();
    put(1'b1, 32'hAA, 4'b0000, 4'd2, 1'b1, 1'b0, 4'h0);
    tick();
    chk("eq_nzcv", {28'd0, bus.nzcv}, 32'h4);
    chk("eq_rd", {28'd0, bus.out_rd}, 32'd2);
    chk("eq_we", {31'd0, bus.out_we}, 32'd1);
    put(1'b1, 32'hBB, 4'b1111, 4'd4, 1'b1, 1'b1, 4'h1);
    tick();
    idle();
    chk("ne_rd", {28'd0, bus.out_rd}, 32'd4);
    chk("ne_we", {31'd0, bus.out_we}, 32'd0);
    chk("ne_nzcv", {28'd0, bus.nzcv}, 32'h4);
    tick();

    // Back-pressure: three offered, two accepted, then drain in order
    bus.out_ready = 1'b0;
    put(1'b1, 32'h11, 4'h0, 4'd5, 1'b1, 1'b0, 4'hE);
    tick();
    put(1'b1, 32'h12, 4'h0, 4'd6, 1'b1, 1'b0, 4'hE);
    tick();
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    put(1'b1, 32'h13, 4'h0, 4'd7, 1'b1, 1'b0, 4'hE);
    tick();
    tick();
    chk("stall_rd", {28'd0, bus.out_rd}, 32'd5);
    chk("stall_data", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("drain1_rd", {28'd0, bus.out_rd}, 32'd6);
    tick();
    idle();
    chk("drain2_rd", {28'd0, bus.out_rd}, 32'd7);
    tick();
    chk("drained", {31'd0, bus.out_valid}, 32'd0);

    // Occupancy 1 with simultaneous push/pop for 4 cycles
    put(1'b1, 32'h30, 4'h0, 4'd0, 1'b1, 1'b0, 4'hE);
    tick();
    for (int k = 1; k <= 4; k++) begin
      put(1'b1, 32'h30 + 32'(k), 4'h0, 4'(k), 1'b1, 1'b0, 4'hE);
      tick();
      chk("steady_rd", {28'd0, bus.out_rd}, 32'(k));
      chk("steady_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    idle();
    tick();

    // Flush when full, and flush discarding an accepted flag-setting input
    bus.out_ready = 1'b0;
    put(1'b1, 32'h21, 4'b0010, 4'd7, 1'b1, 1'b1, 4'hE);
    tick();
    put(1'b1, 32'h22, 4'b0000, 4'd8, 1'b1, 1'b0, 4'hE);
    tick();
    put(1'b1, 32'h23, 4'b1111, 4'd9, 1'b1, 1'b1, 4'hE);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_full_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_full_nzcv", {28'd0, bus.nzcv}, 32'h2);
    put(1'b1, 32'h24, 4'b0000, 4'd10, 1'b1, 1'b0, 4'hE);
    tick();
    put(1'b1, 32'h25, 4'b1111, 4'd11, 1'b1, 1'b1, 4'hE);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_disc_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_disc_nzcv", {28'd0, bus.nzcv}, 32'h2);
    tick();

    // Every condition code against every flag value, back to back
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        put(1'b1, 32'(c * 16 + f), 4'(f), 4'(f), 1'b1, 1'b1, 4'hE);
        tick();
        put(1'b1, 32'h100 + 32'(c), 4'(15 - f), 4'(c), 1'b1, 1'b0, 4'(c));
        tick();
      end
    end
    idle();
    tick();
    // Literal pins of the model: GT with flags 1001 (N=V, !Z) passes;
    // LE with same flags fails
    put(1'b1, 32'h1, 4'b1001, 4'd1, 1'b1, 1'b1, 4'hE);
    tick();
    put(1'b1, 32'h2, 4'b0000, 4'd2, 1'b1, 1'b0, 4'hC);
    tick();
    chk("gt_we", {31'd0, bus.out_we}, 32'd1);
    put(1'b1, 32'h3, 4'b0000, 4'd3, 1'b1, 1'b0, 4'hD);
    tick();
    idle();
    chk("le_we", {31'd0, bus.out_we}, 32'd0);
    tick();

    // Asynchronous reset between edges with two entries held
    bus.out_ready = 1'b0;
    put(1'b1, 32'h41, 4'b1010, 4'd1, 1'b1, 1'b1, 4'hE);
    tick();
    put(1'b1, 32'h42, 4'b0000, 4'd2, 1'b1, 1'b0, 4'hE);
    tick();
    idle();
    chk("pre_rst_nzcv", {28'd0, bus.nzcv}, 32'hA);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_nzcv", {28'd0, bus.nzcv}, 32'd0);
    chk("async_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("async_we", {31'd0, bus.out_we}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ready_after_rst2", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
